// File: rtl/neumaier_pkg.sv
// Shared constants and helpers for the multi-channel Neumaier accumulator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package neumaier_pkg;

  // Depth of the per-element update pipeline (accept edge to writeback edge).
  localparam int STEP_LAT = 3;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/abs_bigger_equal.sv
// Magnitude compare of two sign-magnitude words: ge = |a| >= |b|.
// Latency: combinational.
// Backpressure: none.
module abs_bigger_equal #(
  parameter int BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic                 ge
);

  // Sign bit is dropped; {exp,mant} ordered as an unsigned integer.
  assign ge = (a[BIT_WIDTH-2:0] >= b[BIT_WIDTH-2:0]);

endmodule

// File: rtl/neumaier_step_pipe.sv
// Three-stage Neumaier update: t=sum+e, comp+=lost low part, sum=t.
// Latency: element entering at edge T appears on wb_* after edge T+2 (written back at T+3).
// Backpressure: none; caller guarantees one element per channel in flight.
module neumaier_step_pipe
  import neumaier_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int CH_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CH_W-1:0]      in_ch,
  input  logic [BIT_WIDTH-1:0] in_elem,
  input  logic                 in_last,
  output logic [CH_W-1:0]      rd_ch,
  input  logic [BIT_WIDTH-1:0] rd_sum,
  input  logic [BIT_WIDTH-1:0] rd_comp,
  output logic                 wb_valid,
  output logic [CH_W-1:0]      wb_ch,
  output logic                 wb_last,
  output logic [BIT_WIDTH-1:0] wb_sum,
  output logic [BIT_WIDTH-1:0] wb_comp
);

  logic                 v1, v2, v3;
  logic                 l1, l2, l3;
  logic [CH_W-1:0]      ch1, ch2, ch3;
  logic [BIT_WIDTH-1:0] e1, e2, s2, c2, t2, s3, c3;
  logic                 ge_d, ge2;

  // State of the channel is read while the element sits in stage 1; no
  // other element of that channel can be in flight, so it is current.
  assign rd_ch = ch1;

  abs_bigger_equal #(.BIT_WIDTH(BIT_WIDTH)) u_cmp (
    .a  (rd_sum),
    .b  (e1),
    .ge (ge_d)
  );

  // Stage 1 captures the element, stage 2 forms t and the branch decision,
  // stage 3 folds the rounding error into the compensation term.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      l1 <= 1'b0; l2 <= 1'b0; l3 <= 1'b0;
      ch1 <= '0; ch2 <= '0; ch3 <= '0;
      e1 <= '0; e2 <= '0; s2 <= '0; c2 <= '0; t2 <= '0; s3 <= '0; c3 <= '0;
      ge2 <= 1'b0;
    end else begin
      v1  <= in_valid;
      l1  <= in_last;
      ch1 <= in_ch;
      e1  <= in_elem;

      v2  <= v1;
      l2  <= l1;
      ch2 <= ch1;
      t2  <= rd_sum + e1;
      s2  <= rd_sum;
      c2  <= rd_comp;
      e2  <= e1;
      ge2 <= ge_d;

      v3  <= v2;
      l3  <= l2;
      ch3 <= ch2;
      s3  <= t2;
      c3  <= c2 + (ge2 ? ((s2 - t2) + e2) : ((e2 - t2) + s2));
    end
  end

  assign wb_valid = v3;
  assign wb_last  = l3;
  assign wb_ch    = ch3;
  assign wb_sum   = s3;
  assign wb_comp  = c3;

endmodule

// File: rtl/neumaier_accum_mc.sv
// Multi-channel Neumaier accumulator with per-channel state and a result FIFO.
// Latency: element accepted at edge T updates its channel at T+3; a last element's result is visible after T+3.
// Backpressure: in_ready_o drops while the channel is busy, or for a last element when FIFO credits run out.
module neumaier_accum_mc
  import neumaier_pkg::*;
#(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int NUM_CH       = 4,
  localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CH_W-1:0]        in_ch_i,
  input  logic [BIT_WIDTH_I-1:0] in_elem_i,
  input  logic                   in_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CH_W-1:0]        out_ch_o,
  output logic [BIT_WIDTH_I-1:0] out_sum_o,
  output logic [BIT_WIDTH_I-1:0] out_comp_o,
  output logic [BIT_WIDTH_I-1:0] out_res_o,
  output logic                   busy_o
);

  localparam int CNT_W = ch_w(NUM_CH + STEP_LAT + 1) + 1;

  typedef struct packed {
    logic [CH_W-1:0]        ch;
    logic [BIT_WIDTH_I-1:0] sum;
    logic [BIT_WIDTH_I-1:0] comp;
    logic [BIT_WIDTH_I-1:0] res;
  } res_t;

  logic [BIT_WIDTH_I-1:0] sum_q  [NUM_CH];
  logic [BIT_WIDTH_I-1:0] comp_q [NUM_CH];
  logic [NUM_CH-1:0]      pending;

  res_t                   mem [NUM_CH];
  logic [CH_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt, lasts_cnt;

  logic                   accept, push, pop, credit_full;
  logic [CH_W-1:0]        rd_ch, wb_ch;
  logic                   wb_valid, wb_last;
  logic [BIT_WIDTH_I-1:0] wb_sum, wb_comp;
  res_t                   head;

  function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] p);
    return (p == CH_W'(NUM_CH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A last element reserves a FIFO slot at accept, so the FIFO can never overflow.
  assign credit_full = ((fifo_cnt + lasts_cnt) >= CNT_W'(NUM_CH));
  assign in_ready_o  = !rst_i && !pending[in_ch_i] && !(in_last_i && credit_full);
  assign accept      = in_valid_i && in_ready_o;
  assign push        = wb_valid && wb_last;
  assign pop         = out_valid_o && out_ready_i;

  neumaier_step_pipe #(.BIT_WIDTH(BIT_WIDTH_I), .CH_W(CH_W)) u_pipe (
    .clk      (clk_i),
    .rst      (rst_i),
    .in_valid (accept),
    .in_ch    (in_ch_i),
    .in_elem  (in_elem_i),
    .in_last  (in_last_i),
    .rd_ch    (rd_ch),
    .rd_sum   (sum_q[rd_ch]),
    .rd_comp  (comp_q[rd_ch]),
    .wb_valid (wb_valid),
    .wb_ch    (wb_ch),
    .wb_last  (wb_last),
    .wb_sum   (wb_sum),
    .wb_comp  (wb_comp)
  );

  // Per-channel running state; a finished sequence restarts its channel from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i]  <= '0;
        comp_q[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (wb_valid) begin
        pending[wb_ch] <= 1'b0;
        sum_q[wb_ch]   <= wb_last ? '0 : wb_sum;
        comp_q[wb_ch]  <= wb_last ? '0 : wb_comp;
      end
      if (accept) pending[in_ch_i] <= 1'b1;
    end
  end

  // Result FIFO in writeback order plus the count of lasts still in the pipe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      lasts_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{ch: wb_ch, sum: wb_sum, comp: wb_comp, res: wb_sum + wb_comp};
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      fifo_cnt  <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      lasts_cnt <= lasts_cnt + CNT_W'(accept && in_last_i) - CNT_W'(push);
    end
  end

  // Head data is masked while empty so the outputs read zero after reset.
  assign head        = mem[rd_ptr];
  assign out_valid_o = (fifo_cnt != '0);
  assign out_ch_o    = out_valid_o ? head.ch   : '0;
  assign out_sum_o   = out_valid_o ? head.sum  : '0;
  assign out_comp_o  = out_valid_o ? head.comp : '0;
  assign out_res_o   = out_valid_o ? head.res  : '0;
  assign busy_o      = (|pending) || out_valid_o;

endmodule

// File: tb/tb_neumaier_accum_mc.sv
// Bench for neumaier_accum_mc: directed corner cases plus random traffic against a scoreboard.
// Latency: checks the 3-edge accept-to-result delay.
// Backpressure: exercises same-channel stalls, FIFO credit stalls and random out_ready_i.
module tb_neumaier_accum_mc;

  localparam int BW  = 8;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [CW-1:0] in_ch_i = '0;
  logic [BW-1:0] in_elem_i = '0;
  logic          in_last_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [CW-1:0] out_ch_o;
  logic [BW-1:0] out_sum_o, out_comp_o, out_res_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int sum;
    int comp;
    int res;
  } exp_t;

  exp_t exp_q[$];
  int   m_sum  [NCH];
  int   m_comp [NCH];

  neumaier_accum_mc #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .NUM_CH(NCH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ch_i     (in_ch_i),
    .in_elem_i   (in_elem_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ch_o    (out_ch_o),
    .out_sum_o   (out_sum_o),
    .out_comp_o  (out_comp_o),
    .out_res_o   (out_res_o),
    .busy_o      (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: sampled mid-cycle, sees every handshake that completes on the next edge.
  always @(negedge clk_i) begin : mon
    int   ch, s, e, t, c;
    exp_t r;
    if (rst_i) begin
      exp_q.delete();
      for (int i = 0; i < NCH; i++) begin
        m_sum[i]  = 0;
        m_comp[i] = 0;
      end
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid_o, 0);
        end else begin
          r = exp_q.pop_front();
          chk("out_ch", out_ch_o, r.ch);
          chk("out_sum", out_sum_o, r.sum);
          chk("out_comp", out_comp_o, r.comp);
          chk("out_res", out_res_o, r.res);
        end
      end
      if (in_valid_i && in_ready_o) begin
        ch = int'(in_ch_i);
        s  = m_sum[ch];
        e  = int'(in_elem_i);
        t  = (s + e) % 256;
        if ((s % 128) >= (e % 128)) c = (m_comp[ch] + (s - t) + e) & 255;
        else                        c = (m_comp[ch] + (e - t) + s) & 255;
        m_sum[ch]  = t;
        m_comp[ch] = c;
        if (in_last_i) begin
          r.ch   = ch;
          r.sum  = t;
          r.comp = c;
          r.res  = (t + c) % 256;
          exp_q.push_back(r);
          m_sum[ch]  = 0;
          m_comp[ch] = 0;
        end
      end
    end
  end

  // Offer one element and hold it until accepted; returns the stall cycles.
  task automatic send(input int ch, input int e, input bit last, output int stalls);
    in_valid_i = 1'b1;
    in_ch_i    = CW'(ch);
    in_elem_i  = BW'(e);
    in_last_i  = last;
    stalls     = 0;
    @(negedge clk_i);
    while (!in_ready_o && stalls < 50) begin
      stalls++;
      @(negedge clk_i);
    end
    if (!in_ready_o) chk("send_timeout", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, busy_o, 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int  st, tot, sent;
    bit  acc;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_out_sum", out_sum_o, 0);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    in_last_i = 1'b1;
    @(negedge clk_i);
    chk("ready_without_valid", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    in_last_i = 1'b0;

    // 3+5+7 on ch0, result three edges after the last accept
    send(0, 3, 0, st);
    send(0, 5, 0, st);
    send(0, 7, 1, st);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      chk("last_to_result_latency", out_valid_o, (k == 4) ? 1 : 0);
    end
    @(posedge clk_i);
    #1;
    wait_idle("idle_after_ch0");

    // Wrapping sum on ch1: 200+100 -> 44
    send(1, 200, 0, st);
    send(1, 100, 1, st);
    wait_idle("idle_after_wrap");

    // Same-channel back-to-back offer stalls 3 cycles
    send(3, 17, 0, st);
    send(3, 33, 1, st);
    chk("same_ch_stall", st, 3);
    wait_idle("idle_after_b2b");

    // Round-robin over all channels without stalls
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send(i % 4, 1, (i >= 12), st);
      tot += st;
    end
    chk("round_robin_stalls", tot, 0);
    wait_idle("idle_after_rr");

    // FIFO full: further lasts blocked, non-last still accepted
    out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) send(c, $urandom_range(0, 255), 1, st);
    repeat (4) @(posedge clk_i);
    #1;
    in_valid_i = 1'b1;
    in_ch_i    = 2'd0;
    in_elem_i  = 8'd11;
    in_last_i  = 1'b1;
    @(negedge clk_i);
    chk("fifo_full_valid", out_valid_o, 1);
    chk("fifo_full_blocks_last", in_ready_o, 0);
    @(negedge clk_i);
    chk("fifo_full_blocks_last_2", in_ready_o, 0);
    @(posedge clk_i);
    #1;
    in_ch_i   = 2'd1;
    in_elem_i = 8'd5;
    in_last_i = 1'b0;
    @(negedge clk_i);
    chk("fifo_full_nonlast_ok", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    wait_idle("idle_after_full");
    send(1, 6, 1, st);
    wait_idle("idle_after_ch1_close");

    // Reset one cycle after a ch2 accept discards it
    send(2, 50, 0, st);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      chk("post_rst_no_result", out_valid_o, 0);
      chk("post_rst_busy", busy_o, 0);
    end
    @(posedge clk_i);
    #1;
    send(2, 9, 1, st);
    wait_idle("idle_after_rst");

    // Random traffic with random output backpressure
    sent = 0;
    acc  = 1'b0;
    for (int cyc = 0; cyc < 4000 && sent < 300; cyc++) begin
      if (!in_valid_i || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid_i = 1'b1;
          in_ch_i    = CW'($urandom_range(0, NCH - 1));
          in_elem_i  = BW'($urandom_range(0, 255));
          in_last_i  = ($urandom_range(0, 3) == 0);
        end else begin
          in_valid_i = 1'b0;
          in_last_i  = 1'b0;
        end
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      acc = in_valid_i && in_ready_o;
      if (acc) sent++;
      @(posedge clk_i);
      #1;
    end
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < NCH; c++) send(c, $urandom_range(0, 255), 1, st);
    wait_idle("final_idle");
    chk("results_outstanding", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
